// File: rtl/div_unit_if.sv
// div_unit_if: handshake and result bundle between the control unit and div_unit.
//   master (control unit): drives div_start, dividend, divisor; receives div_zero, div_ready, busy, hi, lo.
//   slave  (divider): the reverse direction.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_zero;
  logic             div_ready;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output div_start, dividend, divisor, input div_zero, div_ready, busy, hi, lo);
  modport slave  (input div_start, dividend, divisor, output div_zero, div_ready, busy, hi, lo);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed restoring divider, one quotient bit per cycle (lo=quotient, hi=remainder).
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : div_unit_if.slave (div_start/dividend/divisor in; div_zero/div_ready/busy/hi/lo out)
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_q, r_rem, r_b, r_hi, r_lo;
  logic             r_sa, r_sb;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_last, w_ge;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_shift;
  logic [WIDTH:0]   w_diff;
  assign w_accept = bus.div_start && r_state == IDLE && bus.divisor != '0;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  assign w_abs_a  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_abs_b  = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  assign w_shift  = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
  // One extra bit so the borrow tells us whether the shifted remainder covers the divisor.
  assign w_diff   = {1'b0, w_shift} - {1'b0, r_b};
  assign w_ge     = ~w_diff[WIDTH];
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = w_accept ? CALC : IDLE;
      CALC: w_next = w_last ? SIGN : CALC;
      SIGN: w_next = DONE;
      DONE: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.busy      = r_state != IDLE;
    bus.div_ready = r_state == DONE;
    bus.div_zero  = bus.div_start && r_state == IDLE && bus.divisor == '0;
    bus.hi        = r_hi;
    bus.lo        = r_lo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      r_rem <= '0;
      r_b   <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_accept) begin
      r_q   <= w_abs_a;
      r_b   <= w_abs_b;
      r_rem <= '0;
      r_cnt <= '0;
      r_sa  <= bus.dividend[WIDTH-1];
      r_sb  <= bus.divisor[WIDTH-1];
    end else if (r_state == CALC) begin
      r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift;
      r_q   <= {r_q[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == SIGN) begin
      r_lo <= (r_sa ^ r_sb) ? -r_q : r_q;
      r_hi <= r_sa ? -r_rem : r_rem;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit against a 64-bit arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_ready = 1'b0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          at;
  } exp_t;
  exp_t sbq[$];
  div_unit_if #(32) bus ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int at);
    longint la, lb, q, r;
    exp_t   e;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q = la / lb;
    r = la % lb;
    e.lo = q[31:0];
    e.hi = r[31:0];
    e.at = at;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (bus.div_ready) begin
      chk("ready_excl", {30'd0, bus.div_zero, prev_ready}, 32'd0);
      if (sbq.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("lo", bus.lo, e.lo);
        chk("hi", bus.hi, e.hi);
        chk("latency", cyc, e.at);
      end
    end
    prev_ready = bus.div_ready;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.div_start = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    if (b != 0) sbq.push_back(model(a, b, cyc + 34));
    #1 chk("div_zero", {31'd0, bus.div_zero}, {31'd0, b == 0});
    tick();
    bus.div_start = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    chk("busy", {31'd0, bus.busy}, {31'd0, b != 0});
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      chk("timeout", 32'd1, 32'd0);
      sbq.delete();
    end
    tick();
  endtask
  initial begin
    int s;
    logic [31:0] a, b;
    bus.div_start = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.div_ready}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    start(32'd100, 32'd7);
    wait_idle();
    start(-32'sd100, 32'd7);
    wait_idle();
    start(32'd5, -32'sd10);
    wait_idle();
    start(32'd7, 32'd0);
    repeat (40) tick();
    chk("zero_busy", {31'd0, bus.busy}, 32'd0);
    chk("zero_hi", bus.hi, 32'd5);
    chk("zero_lo", bus.lo, 32'd0);
    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    start(32'hFFFF_FFFF, 32'h7FFF_FFFF);
    wait_idle();
    s = cyc;
    start(32'd1000, 32'd3);
    while (cyc < s + 10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbq.delete();
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    repeat (40) tick();
    start(32'd9, 32'd3);
    wait_idle();
    s = cyc;
    start(32'd50, 32'd5);
    while (cyc < s + 5) tick();
    bus.div_start = 1'b1;
    bus.dividend  = 32'd123;
    bus.divisor   = 32'd0;
    #1 chk("busy_zero", {31'd0, bus.div_zero}, 32'd0);
    tick();
    bus.div_start = 1'b0;
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = $urandom_range(1, 20);
      if (i % 5 == 1) b = -$urandom_range(1, 20);
      if (b == 0) b = 32'd1;
      start(a, b);
      wait_idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
